// File: rtl/ball_sprite_sched.sv
// Two-ball sprite scheduler sharing one mask lookup during VGA scan.
// Double-buffered positions, 2-cycle pixel pipeline, per-frame hit counters.
module ball_sprite_sched #(
   parameter int SPR_W = 50,
   parameter int SPR_H = 48,
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             valid,
   input  logic             frame_start,
   input  logic [9:0]       ball0_x,
   input  logic [9:0]       ball0_y,
   input  logic [9:0]       ball1_x,
   input  logic [9:0]       ball1_y,
   input  logic             ball0_en,
   input  logic             ball1_en,
   input  logic             upd_req,
   output logic             upd_ack,
   output logic [15:0]      sprite_pos,
   input  logic             sprite_white,
   output logic             pix_valid,
   output logic             pix_hit,
   output logic             pix_id,
   output logic [CNT_W-1:0] hit_cnt0,
   output logic [CNT_W-1:0] hit_cnt1
);

   typedef enum logic {RUN, LOAD} state_t;

   state_t           r_state;
   logic             r_ack;
   logic [9:0]       r_x0, r_y0, r_x1, r_y1;
   logic             r_en0, r_en1;
   logic             r_s1_valid, r_s1_in, r_s1_id;
   logic [5:0]       r_dx, r_dy;
   logic             r_pv, r_ph, r_pid;
   logic [CNT_W-1:0] r_run0, r_run1, r_cnt0, r_cnt1;

   logic             w_in0, w_in1;
   logic [9:0]       w_xs, w_ys;
   logic [5:0]       w_dx, w_dy;
   logic [CNT_W-1:0] w_nxt0, w_nxt1;

   // Shadow position load at frame boundary, one-cycle ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_ack   <= 1'b0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_en0   <= 1'b0;
         r_en1   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            RUN: begin
               if (frame_start && upd_req) begin
                  r_state <= LOAD;
                  r_ack   <= 1'b1;
                  r_x0    <= ball0_x;
                  r_y0    <= ball0_y;
                  r_x1    <= ball1_x;
                  r_y1    <= ball1_y;
                  r_en0   <= ball0_en;
                  r_en1   <= ball1_en;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   // Box tests at 11 bits so boxes near the right/bottom edge do not wrap
   assign w_in0 = r_en0 & valid
                & (h_cnt >= r_x0)
                & ({1'b0, h_cnt} < ({1'b0, r_x0} + 11'(SPR_W)))
                & (v_cnt >= r_y0)
                & ({1'b0, v_cnt} < ({1'b0, r_y0} + 11'(SPR_H)));
   assign w_in1 = r_en1 & valid
                & (h_cnt >= r_x1)
                & ({1'b0, h_cnt} < ({1'b0, r_x1} + 11'(SPR_W)))
                & (v_cnt >= r_y1)
                & ({1'b0, v_cnt} < ({1'b0, r_y1} + 11'(SPR_H)));

   // Ball 0 wins overlaps; offsets only need their low 6 bits
   assign w_xs = w_in0 ? r_x0 : r_x1;
   assign w_ys = w_in0 ? r_y0 : r_y1;
   assign w_dx = h_cnt[5:0] - w_xs[5:0];
   assign w_dy = v_cnt[5:0] - w_ys[5:0];

   // Stage 1: selected ball and in-sprite offset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_in    <= 1'b0;
         r_s1_id    <= 1'b0;
         r_dx       <= '0;
         r_dy       <= '0;
      end else begin
         r_s1_valid <= valid;
         r_s1_in    <= w_in0 | w_in1;
         r_s1_id    <= ~w_in0 & w_in1;
         r_dx       <= w_dx;
         r_dy       <= w_dy;
      end
   end

   assign sprite_pos = r_s1_in ?
                       (16'(r_dy) * 16'(SPR_W) + 16'(r_dx)) : 16'd0;

   // Stage 2: registered hit result from the shared lookup
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pv  <= 1'b0;
         r_ph  <= 1'b0;
         r_pid <= 1'b0;
      end else begin
         r_pv  <= r_s1_valid;
         r_ph  <= r_s1_valid & r_s1_in & ~sprite_white;
         r_pid <= r_s1_id;
      end
   end

   assign w_nxt0 = (r_ph && !r_pid && r_run0 != '1) ?
                   r_run0 + CNT_W'(1) : r_run0;
   assign w_nxt1 = (r_ph && r_pid && r_run1 != '1) ?
                   r_run1 + CNT_W'(1) : r_run1;

   // Saturating running counts, snapshotted and cleared at frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run0 <= '0;
         r_run1 <= '0;
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (frame_start) begin
         r_cnt0 <= w_nxt0;
         r_cnt1 <= w_nxt1;
         r_run0 <= '0;
         r_run1 <= '0;
      end else begin
         r_run0 <= w_nxt0;
         r_run1 <= w_nxt1;
      end
   end

   assign upd_ack   = r_ack;
   assign pix_valid = r_pv;
   assign pix_hit   = r_ph;
   assign pix_id    = r_pid;
   assign hit_cnt0  = r_cnt0;
   assign hit_cnt1  = r_cnt1;

endmodule

// File: doc/ball_sprite_sched.md
Name: ball_sprite_sched

Overview:
- Shares one combinational ball-sprite mask lookup (SPR_W x SPR_H, row-major, `pos = row*SPR_W + col`, `white=0` means ball pixel) between two ball objects during VGA scan.
- Per pixel it selects the owning ball by bounding-box priority, drives the lookup address, and registers the hit result.
- Ball positions are double-buffered: they change only at frame boundaries, through a request/acknowledge handshake with the game logic.
- Per-frame hit counters are provided to the scoring/collision logic.

Parameters:
- SPR_W, 50, sprite width in pixels
- SPR_H, 48, sprite height in pixels
- CNT_W, 12, width of the per-ball per-frame hit counters

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-high reset
- h_cnt  in  10  current scan column
- v_cnt  in  10  current scan row
- valid  in  1  scan position is inside the active display area
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- ball0_x, ball0_y  in  10 each  requested top-left corner of ball 0
- ball1_x, ball1_y  in  10 each  requested top-left corner of ball 1
- ball0_en, ball1_en  in  1 each  requested visibility of each ball
- upd_req  in  1  level request to load the new positions/enables
- upd_ack  out  1  one-cycle pulse: request consumed
- sprite_pos  out  16  address to the sprite mask lookup
- sprite_white  in  1  lookup result (0 = ball pixel), combinational from sprite_pos
- pix_valid  out  1  pipelined `valid`
- pix_hit  out  1  pixel belongs to a ball
- pix_id  out  1  ball index owning the pixel (meaningful when pix_hit=1)
- hit_cnt0, hit_cnt1  out  CNT_W each  ball hit-pixel counts of the previous frame

Behaviour:
- **Reset values:** shadow positions 0, shadow enables 0, all pipeline valid flags 0. Outputs: upd_ack=0, sprite_pos=0, pix_valid=0, pix_hit=0, pix_id=0, hit_cnt0/1=0. Running counters are 0; FSM is in RUN. Reset may assert mid-frame; it clears everything immediately, and output resumes on the first pixel after release.
- **FSM:**
  - RUN: shadow registers hold.
  - LOAD: entered on a cycle where frame_start=1 and upd_req=1.
  - In the LOAD cycle, shadow regs take ball*_x/y/en and upd_ack=1 for exactly that cycle.
  - Next state is always RUN.
  - upd_req without frame_start waits; upd_ack stays 0.
  - Requester must hold upd_req and the data until upd_ack. Requester drops upd_req after upd_ack; if it is still high at the next frame_start, the block reloads and acks again.
- **Box test (stage 0, combinational on inputs + shadow regs):**
  - inside_i = en_i & valid & (h_cnt >= x_i) & (h_cnt < x_i+SPR_W) & (v_cnt >= y_i) & (v_cnt < y_i+SPR_H).
  - Sums are computed at 11 bits, so boxes near 1023 do not wrap.
  - Ball 0 has priority when both boxes contain the pixel. Ball 1 beneath a transparent ball-0 pixel is NOT shown.
  - Selected dx = h_cnt - x_sel, dy = v_cnt - y_sel (6 bits each).
- **Stage 1 register** (cycle +1): s1_valid, s1_in, s1_id, dx, dy.
  - sprite_pos = dy*SPR_W + dx (16 bits) is driven from these registers.
  - sprite_pos = 0 when s1_in=0.
- **Stage 2 register** (cycle +2):
  - pix_valid = s1_valid
  - pix_hit = s1_valid & s1_in & ~sprite_white
  - pix_id = s1_id
  - Total latency from h_cnt/v_cnt to pix_*: 2 cycles, fully pipelined, one pixel per clock.
- **Counters:**
  - A running counter for pix_id increments on each cycle with pix_hit=1, saturating at 2^CNT_W-1.
  - On frame_start, hit_cnt0/1 take the running values (including a hit in that same cycle), and the running counters clear to 0.
- **Position change timing:** a LOAD in cycle t affects box tests from cycle t+1. Pixels already in stages 1-2 complete with the old positions.

Test Plan:
- Reset then idle → all outputs 0; `valid` scan with en=0 → pix_valid follows valid delayed 2 cycles, pix_hit stays 0.
- upd_req=1 with ball0=(100,50,en=1) and no frame_start for 10 cycles → upd_ack=0. Then frame_start → upd_ack=1 for one cycle, FSM returns to RUN.
- Ball0 at (100,50), scan h=114 v=55 → sprite_pos=264 one cycle later. Lookup white=0 → pix_hit=1, pix_id=0 at cycle +2. Scan h=100 v=50 → sprite_pos=0; white=1 → pix_hit=0.
- Ball0 (100,50) and ball1 (120,60) overlapping, scan h=130 v=70 → pix_id=0, sprite_pos=20*50+30=1030. Ball0 en=0 → pix_id=1, sprite_pos=10*50+10=510.
- Ball0 at (1000,50), scan h=1023 v=50 → in box, dx=23, no wrap. Scan h=149 with x=100 → in box; scan h=150 → out of box.
- Frame with 7 ball-0 hits and 3 ball-1 hits, then frame_start → hit_cnt0=7, hit_cnt1=3. Assert rst mid-frame → counters and pix_* clear to 0 immediately.
